// File: rtl/flp_iadd_arb.sv
// Two-requester arbiter feeding a registered shared adder; result 2 cycles after accept, one per cycle.
// i_res_ready low stalls S2 then S1 (two results buffered); FLP_IADD_ARB_RR_EN selects round-robin over fixed priority.
module flp_iadd_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic             i_req0_sn1,
  input  logic [WIDTH-1:0] i_req0_sg1,
  input  logic             i_req0_sn2,
  input  logic [WIDTH-1:0] i_req0_sg2,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic             i_req1_sn1,
  input  logic [WIDTH-1:0] i_req1_sg1,
  input  logic             i_req1_sn2,
  input  logic [WIDTH-1:0] i_req1_sg2,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_id,
  output logic             o_sn,
  output logic [WIDTH:0]   o_sg,
  output logic             o_zero
);

  logic             s1_valid, s1_id, s1_sn1, s1_sn2;
  logic [WIDTH-1:0] s1_sg1, s1_sg2;
  logic             s2_valid, s2_id, s2_sn, s2_zero;
  logic [WIDTH:0]   s2_sg;

  logic s1_adv, s2_adv;
  logic grant0, grant1;

`ifdef FLP_IADD_ARB_RR_EN
  logic last;

  // last resets to 1 so requester 0 wins the first contention
  assign grant0 = i_req0_valid & (~i_req1_valid | last);
  assign grant1 = i_req1_valid & (~i_req0_valid | ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (o_req0_ready & i_req0_valid) begin
      last <= 1'b0;
    end else if (o_req1_ready & i_req1_valid) begin
      last <= 1'b1;
    end
  end
`else
  assign grant0 = i_req0_valid;
  assign grant1 = i_req1_valid & ~i_req0_valid;
`endif

  assign s2_adv = ~s2_valid | i_res_ready;
  assign s1_adv = ~s1_valid | s2_adv;

  assign o_req0_ready = ~rst & s1_adv & grant0;
  assign o_req1_ready = ~rst & s1_adv & grant1;

  // Negating a zero magnitude yields 0, so -0 needs no special case here
  function automatic logic [WIDTH+1:0] to_tc(input logic sn, input logic [WIDTH-1:0] sg);
    logic [WIDTH+1:0] mag;
    mag = {2'b00, sg};
    return sn ? -mag : mag;
  endfunction

  logic [WIDTH+1:0] sum;
  logic             add_sn, add_zero;
  logic [WIDTH:0]   add_sg;

  always_comb begin
    sum      = to_tc(s1_sn1, s1_sg1) + to_tc(s1_sn2, s1_sg2);
    add_sn   = sum[WIDTH+1] | (s1_sn1 & s1_sn2);
    add_zero = ~|sum;
    add_sg   = add_sn ? -sum[WIDTH:0] : sum[WIDTH:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_sn1   <= 1'b0;
      s1_sg1   <= '0;
      s1_sn2   <= 1'b0;
      s1_sg2   <= '0;
    end else if (s1_adv) begin
      s1_valid <= grant0 | grant1;
      if (grant0) begin
        s1_id  <= 1'b0;
        s1_sn1 <= i_req0_sn1;
        s1_sg1 <= i_req0_sg1;
        s1_sn2 <= i_req0_sn2;
        s1_sg2 <= i_req0_sg2;
      end else if (grant1) begin
        s1_id  <= 1'b1;
        s1_sn1 <= i_req1_sn1;
        s1_sg1 <= i_req1_sg1;
        s1_sn2 <= i_req1_sn2;
        s1_sg2 <= i_req1_sg2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_sn    <= 1'b0;
      s2_sg    <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id   <= s1_id;
        s2_sn   <= add_sn;
        s2_sg   <= add_sg;
        s2_zero <= add_zero;
      end
    end
  end

  assign o_res_valid = s2_valid;
  assign o_res_id    = s2_id;
  assign o_sn        = s2_sn;
  assign o_sg        = s2_sg;
  assign o_zero      = s2_zero;

endmodule

// File: tb/tb_flp_iadd_arb.sv
// Directed bench for flp_iadd_arb (WIDTH=32): arithmetic edge cases, contention, backpressure, mid-stream reset.
module tb_flp_iadd_arb;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req0_sn1, req0_sn2;
  logic [31:0] req0_sg1, req0_sg2;
  logic        req1_valid, req1_ready, req1_sn1, req1_sn2;
  logic [31:0] req1_sg1, req1_sg2;
  logic        res_valid, res_ready, res_id, sn, zero;
  logic [32:0] sg;

  int checks = 0;
  int errors = 0;

  flp_iadd_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_sn1(req0_sn1), .i_req0_sg1(req0_sg1),
    .i_req0_sn2(req0_sn2), .i_req0_sg2(req0_sg2),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_sn1(req1_sn1), .i_req1_sg1(req1_sg1),
    .i_req1_sn2(req1_sn2), .i_req1_sg2(req1_sg2),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_id(res_id), .o_sn(sn), .o_sg(sg), .o_zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic v, input logic a_sn1, input logic [31:0] a_sg1,
                         input logic a_sn2, input logic [31:0] a_sg2);
    if (r == 1'b0) begin
      req0_valid = v; req0_sn1 = a_sn1; req0_sg1 = a_sg1; req0_sn2 = a_sn2; req0_sg2 = a_sg2;
    end else begin
      req1_valid = v; req1_sn1 = a_sn1; req1_sg1 = a_sg1; req1_sn2 = a_sn2; req1_sg2 = a_sg2;
    end
  endtask

  // One isolated transaction: ready now, nothing after 1 cycle, result after 2, drained after 3
  task automatic run_one(input string tag, input logic r, input logic a_sn1, input logic [31:0] a_sg1,
                         input logic a_sn2, input logic [31:0] a_sg2,
                         input logic e_sn, input logic [32:0] e_sg, input logic e_zero);
    set_req(r, 1'b1, a_sn1, a_sg1, a_sn2, a_sg2);
    #1;
    chk({tag, "_rdy"}, (r == 1'b0) ? req0_ready : req1_ready, 1);
    cyc();
    set_req(r, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk({tag, "_vld_n1"}, res_valid, 0);
    cyc();
    chk({tag, "_vld"}, res_valid, 1);
    chk({tag, "_id"}, res_id, r);
    chk({tag, "_sn"}, sn, e_sn);
    chk({tag, "_sg"}, sg, e_sg);
    chk({tag, "_zero"}, zero, e_zero);
    cyc();
    chk({tag, "_drain"}, res_valid, 0);
  endtask

  initial begin
    int acc;
    int k;
    logic exp_id;

    rst = 1'b1;
    res_ready = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rst_vld", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_sn", sn, 0);
    chk("rst_sg", sg, 0);
    chk("rst_zero", zero, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    run_one("add5m3", 1'b0, 1'b0, 32'd5, 1'b1, 32'd3, 1'b0, 33'd2, 1'b0);
    run_one("cancel", 1'b0, 1'b0, 32'd7, 1'b1, 32'd7, 1'b0, 33'd0, 1'b1);
    run_one("negzero", 1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 33'd0, 1'b1);
    run_one("maxpos", 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 33'h1FFFFFFFE, 1'b0);
    run_one("maxneg", 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b1, 33'h100000000, 1'b0);
    run_one("req1", 1'b1, 1'b1, 32'd3, 1'b0, 32'd10, 1'b0, 33'd7, 1'b0);

    // Contention: req0 computes 1+1, req1 computes 2+2
    set_req(1'b0, 1'b1, 1'b0, 32'd1, 1'b0, 32'd1);
    set_req(1'b1, 1'b1, 1'b0, 32'd2, 1'b0, 32'd2);
    #1;
`ifndef FLP_IADD_ARB_RR_EN
    chk("fixed_rdy1", req1_ready, 0);
`endif
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
`ifdef FLP_IADD_ARB_RR_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
`endif
      chk($sformatf("cont%0d_vld", i), res_valid, 1);
      chk($sformatf("cont%0d_id", i), res_id, exp_id);
      chk($sformatf("cont%0d_sg", i), sg, exp_id ? 33'd4 : 33'd2);
      cyc();
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    cyc();
    cyc();
    chk("cont_drain", res_valid, 0);

    // Backpressure: four stalled cycles with req0 streaming 10,11,12,...
    res_ready = 1'b0;
    acc = 0;
    k = 0;
    set_req(1'b0, 1'b1, 1'b0, 32'd10, 1'b0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (req0_ready) begin
        acc++;
        k++;
      end
      if (c >= 2) begin
        chk($sformatf("bp%0d_vld", c), res_valid, 1);
        chk($sformatf("bp%0d_sg", c), sg, 33'd10);
        chk($sformatf("bp%0d_rdy", c), req0_ready, 0);
      end
      cyc();
      req0_sg1 = 32'd10 + 32'(k);
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("bp_accepts", acc, 2);
    res_ready = 1'b1;
    #1;
    chk("bp_rel0_vld", res_valid, 1);
    chk("bp_rel0_sg", sg, 33'd10);
    cyc();
    chk("bp_rel1_vld", res_valid, 1);
    chk("bp_rel1_sg", sg, 33'd11);
    cyc();
    chk("bp_rel2_vld", res_valid, 0);

    // Fill S1 and S2, then reset asynchronously mid-cycle
    res_ready = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'd20, 1'b0, 32'd0);
    cyc();
    req0_sg1 = 32'd21;
    cyc();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("full_vld", res_valid, 1);
    chk("full_sg", sg, 33'd20);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", res_valid, 0);
    chk("arst_sg", sg, 0);
    chk("arst_sn", sn, 0);
    chk("arst_zero", zero, 0);
    cyc();
    rst = 1'b0;
    res_ready = 1'b1;
    cyc();
    chk("post_rst_empty", res_valid, 0);
    run_one("post_rst", 1'b0, 1'b0, 32'd30, 1'b1, 32'd0, 1'b0, 33'd30, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
